// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op classification for the HI/LO mul/div unit.
// Latency: none (types and a pure function only).
// Backpressure: none.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // True for the multi-cycle ops that occupy the unit and stall EX.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 divider on operand magnitudes, sign fix-up on the way out.
// Latency: XLEN iteration cycles after start; divisor 0 resolves at the start edge.
// Backpressure: none; result stays put until the next start or abort.
module div_radix2_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              abort,
  output logic [2*XLEN-1:0] result,     // {remainder, quotient}
  output logic              res_valid   // final iteration completes on this edge
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic            running;
  logic [CW-1:0]   it_cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;      // shifts dividend bits out, quotient bits in
  logic [XLEN-1:0] bmag_q;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   diff;

  assign a_mag   = (sign && a[XLEN-1]) ? -a : a;
  assign b_mag   = (sign && b[XLEN-1]) ? -b : b;
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign diff    = partial - {1'b0, bmag_q};

  // Operand capture at start, one restoring step per cycle while running.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      running <= 1'b0;
      it_cnt  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start) begin
      it_cnt <= '0;
      bmag_q <= b_mag;
      if (b == '0) begin
        // Divide by zero: the architectural result is fixed, no iterations.
        running <= 1'b0;
        rem_q   <= a;
        quo_q   <= '1;
        neg_q   <= 1'b0;
        neg_r   <= 1'b0;
      end else begin
        running <= 1'b1;
        rem_q   <= '0;
        quo_q   <= a_mag;
        neg_q   <= sign & (a[XLEN-1] ^ b[XLEN-1]);
        neg_r   <= sign & a[XLEN-1];
      end
    end else if (running) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= partial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      if (it_cnt == CW'(XLEN-1)) begin
        running <= 1'b0;
      end else begin
        it_cnt <= it_cnt + 1'b1;
      end
    end
  end

  // Signed fix-up: quotient sign from the operand XOR, remainder follows the dividend.
  always_comb begin
    result    = {(neg_r ? -rem_q : rem_q), (neg_q ? -quo_q : quo_q)};
    res_valid = running && (it_cnt == CW'(XLEN-1));
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO.
// Latency: MUL commits MUL_STAGES cycles after accept, DIV XLEN+1, divide-by-zero 1.
// Backpressure: busy stalls EX until DONE; hold keeps the result parked in DONE.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             res_is_div;

  logic             mul_accept;
  logic             div_accept;
  logic             mul_sign;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] mul_pipe [MUL_STAGES];

  logic [2*XLEN-1:0] div_result;
  logic              div_res_valid;
  logic [2*XLEN-1:0] result;

  assign mul_accept = (state == ST_IDLE) && op_valid && is_mul(op) && !flush;
  assign div_accept = (state == ST_IDLE) && op_valid && is_div(op) && !flush;

  // Full-width product of sign- or zero-extended operands; low 2*XLEN bits are exact.
  assign mul_sign = (op == MD_MULT);
  assign a_ext    = {{XLEN{mul_sign & src_a[XLEN-1]}}, src_a};
  assign b_ext    = {{XLEN{mul_sign & src_b[XLEN-1]}}, src_b};
  assign product  = a_ext * b_ext;

  // Product register chain; frozen outside accept/MUL so DONE holds a stable result.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else if (mul_accept || (state == ST_MUL)) begin
      mul_pipe[0] <= product;
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  div_radix2_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_accept),
    .sign      (op == MD_DIV),
    .a         (src_a),
    .b         (src_b),
    .abort     (flush),
    .result    (div_result),
    .res_valid (div_res_valid)
  );

  assign result = res_is_div ? div_result : mul_pipe[MUL_STAGES-1];

  // Sequencing FSM and HI/LO architectural state; flush beats commit and moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      res_is_div <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      res_is_div <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (is_mul(op)) begin
              res_is_div <= 1'b0;
              if (MUL_STAGES == 1) begin
                state <= ST_DONE;
              end else begin
                state <= ST_MUL;
                cnt   <= CW'(1);   // the accept cycle is the first multiplier stage
              end
            end else if (is_div(op)) begin
              res_is_div <= 1'b1;
              state      <= (src_b == '0) ? ST_DONE : ST_DIV;
            end else if (op == MD_MTHI && !hold) begin
              hi <= src_a;
            end else if (op == MD_MTLO && !hold) begin
              lo <= src_a;
            end
          end
        end
        ST_MUL: begin
          if (cnt == CW'(MUL_STAGES-1)) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DIV: begin
          if (div_res_valid) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!hold) begin
            hi    <= result[2*XLEN-1:XLEN];
            lo    <= result[XLEN-1:0];
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // EX stall while the op is being accepted or computed; released once the result is parked.
  always_comb begin
    busy = op_valid && is_muldiv(op) && (state != ST_DONE);
    done = (state == ST_DONE) && !hold && !flush && !rst;
  end

endmodule
